// File: rtl/dlx_pkg.sv
// Shared DLX types, constants and saturating-counter helpers for the branch predictor.
package dlx_pkg;

    localparam int unsigned DLX_XLEN      = 32;
    localparam logic [31:0] DLX_NOP       = 32'h00000015;
    localparam int unsigned DLX_ENTRIES   = 16;
    localparam int unsigned DLX_CTR_BITS  = 2;
    localparam int unsigned DLX_IDX_BITS  = $clog2(DLX_ENTRIES);
    localparam int unsigned DLX_TAG_BITS  = DLX_XLEN - 2 - DLX_IDX_BITS;
    localparam int unsigned CTR_MAX_BITS  = 3;

    typedef struct packed {
        logic                     valid;
        logic [DLX_TAG_BITS-1:0]  tag;
        logic [DLX_XLEN-1:0]      target;
        logic [DLX_CTR_BITS-1:0]  ctr;
    } btb_entry_t;

    // Counters up to CTR_MAX_BITS wide; 'bits' selects the saturation point.
    function automatic logic [CTR_MAX_BITS-1:0] ctr_inc(input logic [CTR_MAX_BITS-1:0] c,
                                                        input int unsigned bits);
        logic [CTR_MAX_BITS-1:0] top;
        top = CTR_MAX_BITS'((32'd1 << bits) - 32'd1);
        return (c >= top) ? top : c + CTR_MAX_BITS'(1);
    endfunction

    function automatic logic [CTR_MAX_BITS-1:0] ctr_dec(input logic [CTR_MAX_BITS-1:0] c);
        return (c == '0) ? '0 : c - CTR_MAX_BITS'(1);
    endfunction

endpackage

// File: rtl/dlx_sat_counter.sv
// Saturating up/down direction counter with parallel load; one instance per BTB entry.
module dlx_sat_counter
    import dlx_pkg::*;
#(
    parameter int unsigned   CTR_BITS = 2,
    parameter logic [CTR_BITS-1:0] RST_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [CTR_BITS-1:0] load_val_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CTR_BITS-1:0] count_o
);

    logic [CTR_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = CTR_BITS'(ctr_inc(CTR_MAX_BITS'(count_q), CTR_BITS));
        end else if (dec_i) begin
            count_d = CTR_BITS'(ctr_dec(CTR_MAX_BITS'(count_q)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dlx_branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, IF lookup and ID mispredict detection.
// Define DLX_BTB_BYPASS_EN to forward a same-cycle table update into the IF lookup.
module dlx_branch_predictor
    import dlx_pkg::*;
#(
    parameter int unsigned XLEN     = DLX_XLEN,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned IDX_BITS = $clog2(ENTRIES),
    parameter int unsigned TAG_BITS = XLEN - 2 - IDX_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_if,
    output logic            predict_taken_if,
    output logic [XLEN-1:0] predict_target_if,
    input  logic            stall_id,
    input  logic            flush_id,
    input  logic            resolve_valid_id,
    input  logic [XLEN-1:0] resolve_pc_id,
    input  logic            resolve_taken_id,
    input  logic [XLEN-1:0] resolve_target_id,
    output logic            mispredict_id,
    output logic [XLEN-1:0] redirect_pc_id
);

    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(32'd1 << (CTR_BITS - 1));

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_w    [ENTRIES];

    logic [IDX_BITS-1:0] l_idx, u_idx;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic                u_hit, upd_fire, alloc;

    logic                pred_taken_q, pred_taken_d;
    logic [XLEN-1:0]     pred_target_q, pred_target_d;

    logic                e_valid;
    logic [TAG_BITS-1:0] e_tag;
    logic [XLEN-1:0]     e_target;
    logic [CTR_BITS-1:0] e_ctr;

    assign l_idx    = pc_if[IDX_BITS+1:2];
    assign l_tag    = pc_if[XLEN-1:IDX_BITS+2];
    assign u_idx    = resolve_pc_id[IDX_BITS+1:2];
    assign u_tag    = resolve_pc_id[XLEN-1:IDX_BITS+2];
    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd_fire = resolve_valid_id && !stall_id && !reset;
    assign alloc    = upd_fire && resolve_taken_id;

    for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_ctr
        logic sel;
        assign sel = (u_idx == IDX_BITS'(g));
        dlx_sat_counter #(
            .CTR_BITS (CTR_BITS),
            .RST_VAL  (CTR_WNT)
        ) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .load_i     (sel && alloc && !u_hit),
            .load_val_i (CTR_WT),
            .inc_i      (sel && alloc && u_hit),
            .dec_i      (sel && upd_fire && !resolve_taken_id && u_hit),
            .count_o    (ctr_w[g])
        );
    end

    always_comb begin
        valid_d = valid_q;
        if (alloc) begin
            valid_d[u_idx] = 1'b1;
        end
    end

    // Tag/target payload needs no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        if (alloc) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= resolve_target_id;
        end
    end

    always_comb begin
        e_valid  = valid_q[l_idx];
        e_tag    = tag_q[l_idx];
        e_target = target_q[l_idx];
        e_ctr    = ctr_w[l_idx];
`ifdef DLX_BTB_BYPASS_EN
        if (upd_fire && (u_idx == l_idx)) begin
            if (resolve_taken_id) begin
                e_valid  = 1'b1;
                e_tag    = u_tag;
                e_target = resolve_target_id;
                e_ctr    = u_hit ? CTR_BITS'(ctr_inc(CTR_MAX_BITS'(ctr_w[u_idx]), CTR_BITS))
                                 : CTR_WT;
            end else if (u_hit) begin
                e_ctr = CTR_BITS'(ctr_dec(CTR_MAX_BITS'(ctr_w[u_idx])));
            end
        end
`endif
        predict_taken_if  = e_valid && (e_tag == l_tag) && e_ctr[CTR_BITS-1] && !reset;
        predict_target_if = predict_taken_if ? e_target : pc_if + XLEN'(4);
    end

    // IF->ID prediction register; flush beats stall.
    always_comb begin
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (flush_id) begin
            pred_taken_d  = 1'b0;
            pred_target_d = '0;
        end else if (!stall_id) begin
            pred_taken_d  = predict_taken_if;
            pred_target_d = predict_target_if;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    always_comb begin
        mispredict_id  = 1'b0;
        redirect_pc_id = '0;
        if (resolve_valid_id) begin
            mispredict_id = (resolve_taken_id != pred_taken_q) ||
                            (resolve_taken_id && (resolve_target_id != pred_target_q));
            if (mispredict_id) begin
                redirect_pc_id = resolve_taken_id ? resolve_target_id
                                                  : resolve_pc_id + XLEN'(4);
            end
        end
    end

endmodule
